ext_sel_stage: RTL

EXT_SEL_STAGE -- requirements
Module: ext_sel_stage

---
 rtl/ext_sel_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ext_sel_stage.sv
// Immediate-extension and operand-select stage with a two-entry elastic buffer.
// The output register and one skid entry hold up to two transactions, so in_ready
// can be a plain register and never depends combinationally on out_ready.
module ext_sel_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int NIN     = 2,
    localparam int SEL_W  = $clog2(NIN + 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IMM_W-1:0]      imm,
    input  logic [1:0]            ext_mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [NIN*DATA_W-1:0] data_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [DATA_W-1:0]     out_ext
);

    logic [DATA_W-1:0] ext_val;
    logic [DATA_W-1:0] sel_val;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] out_ext_q, out_ext_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [DATA_W-1:0] skid_ext_q, skid_ext_d;
    logic              in_ready_q;

    logic accept;
    logic out_xfer;

    assign accept   = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Extend the raw immediate according to ext_mode.
    always_comb begin
        ext_val = '0;
        case (ext_mode)
            2'd0:    ext_val = DATA_W'(imm);
            2'd1:    ext_val = DATA_W'($signed(imm));
            2'd2:    ext_val = DATA_W'(imm) << (DATA_W - IMM_W);
            default: ext_val = DATA_W'($signed(imm[7:0]));
        endcase
    end

    // Pick a register operand, the extended immediate, or zero for out-of-range selects.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NIN; k++) begin
            if (int'(sel) == k) begin
                sel_val = data_in[k*DATA_W +: DATA_W];
            end
        end
        if (int'(sel) == NIN) begin
            sel_val = ext_val;
        end
    end

    // Next-state for the output register and skid entry; flush wins over everything.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ext_d    = out_ext_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ext_d   = skid_ext_q;
        if (flush) begin
            // Payload registers keep their contents; only the valid bits drop.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                // Skid drains into the output; a new input refills the skid.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_ext_d    = skid_ext_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = sel_val;
                    skid_ext_d  = ext_val;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = sel_val;
                    out_ext_d  = ext_val;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_val;
            skid_ext_d   = ext_val;
        end
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ext_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ext_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ext_q    <= out_ext_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ext_q   <= skid_ext_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ext   = out_ext_q;

endmodule
